blake2_ctrl: RTL and testbench
==============================

BLAKE2_CTRL -- requirements
Module: blake2_ctrl

Interface
REQ-001 Parameter BLOCK_BYTES, default 64, bytes per compression block (BLAKE2s).
REQ-002 Parameter OUT_MAX, default 32, maximum digest length nn in bytes.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 nreset  in  1  reset, synchronous, active-low.
REQ-005 kk_i  in  6  key length in bytes, sampled at block start.
REQ-006 nn_i  in  6  digest length in bytes, sampled at block start.
REQ-007 ll_i  in  64  total message length in bytes, sampled at block start.
REQ-008 data_v_i  in  1  one message byte accepted this cycle.
REQ-009 data_idx_i  in  6  byte index within the current block.
REQ-010 block_first_i  in  1  current block is the first block of the message.
REQ-011 block_last_i  in  1  current block is the last block of the message.
REQ-012 comp_start_o  out  1  one-cycle pulse that starts compression.
REQ-013 comp_init_o  out  1  reload h from IV/parameter block; valid with comp_start_o.
REQ-014 comp_final_o  out  1  BLAKE2 f0 finalisation flag; valid with comp_start_o.
REQ-015 comp_t_o  out  64  byte counter t; valid with comp_start_o.
REQ-016 comp_done_i  in  1  compression finished; single-cycle pulse.
REQ-017 ready_v_o  out  1  controller can accept block bytes.
REQ-018 hash_v_o  out  1  digest byte strobe.
REQ-019 hash_idx_o  out  6  digest byte index that the datapath drives onto hash_o.
REQ-020 err_o  out  1  sticky protocol-error flag.

Function
REQ-021 FSM states: IDLE, RECV, COMP, OUT.
REQ-022 IDLE: ready_v_o=1; on data_v_i go to RECV; if block_first_i, latch kk/nn/ll and clear t to 0.
REQ-023 RECV: ready_v_o=1; on data_v_i with data_idx_i==BLOCK_BYTES-1, go to COMP on the next cycle and latch block_first_i/block_last_i.
REQ-024 Entering COMP: assert comp_start_o for exactly one cycle. comp_init_o = latched first. comp_final_o = latched last.
REQ-025 comp_t_o on a non-last block = t_prev + BLOCK_BYTES, and t is updated to that value.
REQ-026 comp_t_o on the last block = ll + (kk!=0 ? BLOCK_BYTES : 0); the addition is mod 2^64.
REQ-027 COMP: ready_v_o=0; hold until comp_done_i. On done, go to OUT if the block was last, otherwise to RECV.
REQ-028 OUT: hash_v_o=1 for nn consecutive cycles with hash_idx_o = 0..nn-1, then go to IDLE.
REQ-029 nn==0 on the last block: skip OUT and go directly to IDLE.
REQ-030 nn>OUT_MAX: clamp to OUT_MAX and set err_o.
REQ-031 data_v_i while in COMP or OUT: ignore the byte and set err_o.
REQ-032 comp_done_i outside COMP: ignore it and set err_o.
REQ-033 comp_done_i in the same cycle as comp_start_o is legal and completes the compression.
REQ-034 Latency: the cycle after byte index 63 is accepted shows comp_start_o=1. The cycle after comp_done_i shows hash_v_o=1 for the last block.

Reset
REQ-035 Reset values: state=IDLE, t=0, err_o=0, comp_start_o=0, hash_v_o=0, hash_idx_o=0, ready_v_o=1.
REQ-036 Reset mid-operation abandons the message; the next data_v_i is treated as a new first block.
REQ-037 Configuration and latched flags need no reset; they are re-latched before use.

Structure
REQ-038 Shared package contains: the state enum, BLOCK_BYTES, OUT_MAX, and the command codes CONF/START/DATA/LAST.
REQ-039 One sub-module, blake2_t_counter: 64-bit t register with increment and last-block load.

Verification
REQ-040 Single block, kk=0, nn=32, ll=3, first+last: comp_start with init=1, final=1, t=3; then 32 hash_v cycles, idx 0..31.
REQ-041 Two blocks, kk=0, ll=100: block 1 t=64, final=0; block 2 t=100, final=1, init=0.
REQ-042 Keyed, kk=16, ll=10, two blocks: key block t=64, final=0; message block t=74, final=1.
REQ-043 data_v_i during COMP: byte ignored, err_o=1 and stays 1 until reset.
REQ-044 nreset low mid-RECV, then a new first block: t restarts at 0, err_o=0, init=1.
REQ-045 nn=0 on the last block: no hash_v_o; FSM returns to IDLE the cycle after comp_done_i.

Source files
------------

// File: rtl/blake2_ctrl_pkg.sv
// Shared definitions for the BLAKE2s block controller: FSM states, sizing
// constants and the byte-counter command codes.
package blake2_ctrl_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int OUT_MAX     = 32;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    COMP,
    OUT
  } state_e;

  // CONF clears t at message start, DATA holds it, START advances by one
  // block, LAST loads the final length (plus the key block when keyed).
  typedef enum logic [1:0] {
    CONF,
    START,
    DATA,
    LAST
  } cmd_e;

endpackage

// File: rtl/blake2_t_counter.sv
// 64-bit BLAKE2 byte counter t: cleared per message, advanced per block,
// loaded with the total length on the last block (all sums mod 2^64).
module blake2_t_counter #(
  parameter int BLOCK_BYTES = blake2_ctrl_pkg::BLOCK_BYTES
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  blake2_ctrl_pkg::cmd_e cmd,
  input  logic                  fresh,
  input  logic [63:0]           ll,
  input  logic                  keyed,
  output logic [63:0]           t
);
  import blake2_ctrl_pkg::*;

  logic [63:0] t_q;
  logic [63:0] t_d;
  logic [63:0] base;

  always_comb begin
    // A block that both opens and closes in IDLE must count from zero.
    base = fresh ? 64'd0 : t_q;
    t_d  = t_q;
    case (cmd)
      CONF:    t_d = 64'd0;
      START:   t_d = base + 64'(BLOCK_BYTES);
      LAST:    t_d = ll + (keyed ? 64'(BLOCK_BYTES) : 64'd0);
      default: t_d = t_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) t_q <= '0;
    else         t_q <= t_d;
  end

  assign t = t_q;

endmodule

// File: rtl/blake2_ctrl.sv
// BLAKE2s block controller: counts block bytes, launches compression with
// init/final/t, then strobes out the digest byte indices.
module blake2_ctrl #(
  parameter int BLOCK_BYTES = blake2_ctrl_pkg::BLOCK_BYTES,
  parameter int OUT_MAX     = blake2_ctrl_pkg::OUT_MAX
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        data_v_i,
  input  logic [5:0]  data_idx_i,
  input  logic        block_first_i,
  input  logic        block_last_i,
  output logic        comp_start_o,
  output logic        comp_init_o,
  output logic        comp_final_o,
  output logic [63:0] comp_t_o,
  input  logic        comp_done_i,
  output logic        ready_v_o,
  output logic        hash_v_o,
  output logic [5:0]  hash_idx_o,
  output logic        err_o
);
  import blake2_ctrl_pkg::*;

  state_e      state_q, state_d;
  logic        start_q;
  logic        err_q, err_d;
  logic [5:0]  hash_idx_q, hash_idx_d;

  logic        keyed_q;
  logic [5:0]  nn_q;
  logic [63:0] ll_q;
  logic        first_q, last_q;

  logic        accept;
  logic        blk_end;
  logic        cfg_latch;
  logic        nn_over;
  logic [5:0]  nn_clamped;
  logic [63:0] ll_eff;
  logic        keyed_eff;
  cmd_e        t_cmd;
  logic [63:0] t_val;

  always_comb begin
    accept     = data_v_i && (state_q == IDLE || state_q == RECV);
    blk_end    = accept && (data_idx_i == 6'(BLOCK_BYTES - 1));
    cfg_latch  = data_v_i && (state_q == IDLE) && block_first_i;
    nn_over    = {26'd0, nn_i} > 32'(OUT_MAX);
    nn_clamped = nn_over ? 6'(OUT_MAX) : nn_i;
    // Config latched this very cycle is not yet in the registers.
    ll_eff     = cfg_latch ? ll_i : ll_q;
    keyed_eff  = cfg_latch ? (kk_i != 6'd0) : keyed_q;
    if (blk_end)        t_cmd = block_last_i ? LAST : START;
    else if (cfg_latch) t_cmd = CONF;
    else                t_cmd = DATA;
  end

  blake2_t_counter #(
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_t_counter (
    .clk   (clk),
    .nreset(nreset),
    .cmd   (t_cmd),
    .fresh (cfg_latch),
    .ll    (ll_eff),
    .keyed (keyed_eff),
    .t     (t_val)
  );

  always_comb begin
    state_d    = state_q;
    hash_idx_d = '0;
    err_d      = err_q;
    if (data_v_i && !accept)                err_d = 1'b1;
    if (comp_done_i && state_q != COMP)     err_d = 1'b1;
    if (cfg_latch && nn_over)               err_d = 1'b1;
    case (state_q)
      IDLE: if (accept)  state_d = blk_end ? COMP : RECV;
      RECV: if (blk_end) state_d = COMP;
      COMP: begin
        if (comp_done_i) begin
          if (!last_q)              state_d = RECV;
          else if (nn_q == 6'd0)    state_d = IDLE;
          else                      state_d = OUT;
        end
      end
      OUT: begin
        if (hash_idx_q == nn_q - 6'd1) state_d = IDLE;
        else                           hash_idx_d = hash_idx_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      hash_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= blk_end;
      err_q      <= err_d;
      hash_idx_q <= hash_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_latch) begin
      keyed_q <= (kk_i != 6'd0);
      nn_q    <= nn_clamped;
      ll_q    <= ll_i;
    end
    if (blk_end) begin
      first_q <= block_first_i;
      last_q  <= block_last_i;
    end
  end

  always_comb begin
    comp_start_o = start_q;
    comp_init_o  = first_q;
    comp_final_o = last_q;
    comp_t_o     = t_val;
    ready_v_o    = (state_q == IDLE) || (state_q == RECV);
    hash_v_o     = (state_q == OUT);
    hash_idx_o   = hash_idx_q;
    err_o        = err_q;
  end

endmodule

// File: tb/tb_blake2_ctrl.sv
// Bench for blake2_ctrl: table of messages plus hand-written error/reset cases.
module tb_blake2_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic [5:0]  kk_i, nn_i, data_idx_i;
  logic [63:0] ll_i;
  logic        data_v_i, block_first_i, block_last_i, comp_done_i;
  logic        comp_start_o, comp_init_o, comp_final_o, ready_v_o, hash_v_o, err_o;
  logic [63:0] comp_t_o;
  logic [5:0]  hash_idx_o;

  always #5 clk = ~clk;

  blake2_ctrl #(.BLOCK_BYTES(64), .OUT_MAX(32)) dut (
    .clk(clk), .nreset(nreset), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .data_v_i(data_v_i), .data_idx_i(data_idx_i),
    .block_first_i(block_first_i), .block_last_i(block_last_i),
    .comp_start_o(comp_start_o), .comp_init_o(comp_init_o),
    .comp_final_o(comp_final_o), .comp_t_o(comp_t_o),
    .comp_done_i(comp_done_i), .ready_v_o(ready_v_o),
    .hash_v_o(hash_v_o), .hash_idx_o(hash_idx_o), .err_o(err_o)
  );

  typedef struct {
    logic        init;
    logic        fin;
    logic [63:0] t;
  } sb_t;

  typedef struct {
    logic [5:0]  kk;
    logic [5:0]  nn;
    logic [63:0] ll;
    int          nblk;
    logic [63:0] tlast;
    int          nout;
    logic        err;
    int          cdly;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   hexp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nreset) begin
      if (comp_start_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start actual=1 required=0");
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("start_init", {63'd0, comp_init_o}, {63'd0, e.init});
          chk("start_final", {63'd0, comp_final_o}, {63'd0, e.fin});
          chk("start_t", comp_t_o, e.t);
        end
      end
      if (hash_v_o) begin
        chk("hash_idx", {58'd0, hash_idx_o}, 64'(hexp));
        hexp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  task automatic send_bytes(input int n, input logic first, input logic last);
    block_first_i = first;
    block_last_i  = last;
    for (int i = 0; i < n; i++) begin
      data_v_i   = 1'b1;
      data_idx_i = 6'(i);
      tick();
    end
    data_v_i = 1'b0;
  endtask

  task automatic do_comp(input int dly);
    repeat (dly) tick();
    comp_done_i = 1'b1;
    tick();
    comp_done_i = 1'b0;
  endtask

  task automatic run_msg(input vec_t v);
    hexp = 0;
    kk_i = v.kk;
    nn_i = v.nn;
    ll_i = v.ll;
    for (int b = 0; b < v.nblk; b++) begin
      logic first, last;
      first = (b == 0);
      last  = (b == v.nblk - 1);
      sb.push_back('{init: first, fin: last, t: last ? v.tlast : 64'(64 * (b + 1))});
      send_bytes(64, first, last);
      chk("start_latency", {63'd0, comp_start_o}, 64'd1);
      do_comp(v.cdly);
      if (!last)           chk("ready_after_done", {63'd0, ready_v_o}, 64'd1);
      else if (v.nout > 0) chk("hash_latency", {63'd0, hash_v_o}, 64'd1);
      else                 chk("idle_after_done", {62'd0, ready_v_o, hash_v_o}, 64'd2);
    end
    repeat (v.nout + 2) tick();
    chk("hash_count", 64'(hexp), 64'(v.nout));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("msg_err", {63'd0, err_o}, {63'd0, v.err});
    chk("idle_ready", {63'd0, ready_v_o}, 64'd1);
  endtask

  initial begin
    nreset = 1'b0; kk_i = '0; nn_i = '0; ll_i = '0;
    data_v_i = 1'b0; data_idx_i = '0; block_first_i = 1'b0;
    block_last_i = 1'b0; comp_done_i = 1'b0;

    vecs[0] = '{kk: 6'd0,  nn: 6'd32, ll: 64'd3,   nblk: 1, tlast: 64'd3,   nout: 32, err: 1'b0, cdly: 2};
    vecs[1] = '{kk: 6'd0,  nn: 6'd32, ll: 64'd100, nblk: 2, tlast: 64'd100, nout: 32, err: 1'b0, cdly: 0};
    vecs[2] = '{kk: 6'd16, nn: 6'd32, ll: 64'd10,  nblk: 2, tlast: 64'd74,  nout: 32, err: 1'b0, cdly: 3};
    vecs[3] = '{kk: 6'd0,  nn: 6'd0,  ll: 64'd5,   nblk: 1, tlast: 64'd5,   nout: 0,  err: 1'b0, cdly: 1};
    vecs[4] = '{kk: 6'd0,  nn: 6'd40, ll: 64'd64,  nblk: 1, tlast: 64'd64,  nout: 32, err: 1'b1, cdly: 0};
    vecs[5] = '{kk: 6'd8,  nn: 6'd16, ll: 64'd200, nblk: 4, tlast: 64'd264, nout: 16, err: 1'b0, cdly: 4};
    vecs[6] = '{kk: 6'd5,  nn: 6'd1,  ll: 64'hFFFF_FFFF_FFFF_FFF0, nblk: 1,
                tlast: 64'h30, nout: 1, err: 1'b0, cdly: 1};

    tick();
    do_reset();
    chk("rst_ready", {63'd0, ready_v_o}, 64'd1);
    chk("rst_start", {63'd0, comp_start_o}, 64'd0);
    chk("rst_hash_v", {63'd0, hash_v_o}, 64'd0);
    chk("rst_hash_idx", {58'd0, hash_idx_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_t", comp_t_o, 64'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_msg(vecs[i]);
    end

    // Stray byte during compression: ignored, error sticks.
    do_reset();
    hexp = 0;
    kk_i = 6'd0; nn_i = 6'd4; ll_i = 64'd1;
    sb.push_back('{init: 1'b1, fin: 1'b1, t: 64'd1});
    send_bytes(64, 1'b1, 1'b1);
    data_v_i = 1'b1; data_idx_i = 6'd0;
    tick();
    data_v_i = 1'b0;
    chk("comp_byte_err", {63'd0, err_o}, 64'd1);
    chk("comp_byte_ready", {63'd0, ready_v_o}, 64'd0);
    do_comp(1);
    repeat (6) tick();
    chk("comp_byte_hash_count", 64'(hexp), 64'd4);
    chk("err_sticky", {63'd0, err_o}, 64'd1);

    // Reset mid-RECV abandons the message and clears the error.
    send_bytes(10, 1'b1, 1'b0);
    chk("recv_ready", {63'd0, ready_v_o}, 64'd1);
    nreset = 1'b0;
    tick();
    chk("midrst_err", {63'd0, err_o}, 64'd0);
    chk("midrst_t", comp_t_o, 64'd0);
    nreset = 1'b1;
    ll_i = 64'd7;
    sb.push_back('{init: 1'b1, fin: 1'b0, t: 64'd64});
    send_bytes(64, 1'b1, 1'b0);
    do_comp(2);
    chk("midrst_recv", {63'd0, ready_v_o}, 64'd1);
    chk("midrst_sb_empty", 64'(sb.size()), 64'd0);

    // comp_done outside COMP is flagged but otherwise ignored.
    do_reset();
    comp_done_i = 1'b1;
    tick();
    comp_done_i = 1'b0;
    chk("idle_done_err", {63'd0, err_o}, 64'd1);
    chk("idle_done_ready", {63'd0, ready_v_o}, 64'd1);
    chk("idle_done_no_hash", {63'd0, hash_v_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
